// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding instruction-memory
// read at a time and hands each fetched word to decode over a valid/ready pair.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic            clk,
  input  logic            rst,

  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,

  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,

  input  logic            halt_in,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] redirect_tgt_s;

  // Targets are forced word-aligned so the PC can never become misaligned.
  assign redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};

  assign imem_addr   = pc_q;
  assign out_inst    = inst_q;
  assign out_pc      = pc_q;
  assign fetch_count = count_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      count_q <= count_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_d         = drop_q;
    inst_d         = inst_q;
    count_d        = count_q;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    halted         = 1'b0;

    case (state_q)
      ST_REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_tgt_s;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_WAIT: begin
        // A response that races a redirect, or follows one, belongs to the old path.
        if (imem_rsp_valid) begin
          if (redirect_valid || drop_q) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
            if (redirect_valid) begin
              pc_d = redirect_tgt_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            inst_d  = imem_rsp_data;
            state_d = ST_OUT;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_tgt_s;
          drop_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_OUT: begin
        out_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d    = redirect_tgt_s;
          state_d = ST_REQ;
        end else if (out_ready) begin
          count_d = count_q + 32'd1;
          if (halt_in) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + XLEN'(32'd4);
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change 1ns after each rising edge and
// outputs are compared 1ns later, well away from the next edge.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic        halted;
  logic [31:0] fetch_count;

  int checks;
  int errors;

  ifu_fetch #(.XLEN(32), .RESET_PC(32'h80000000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt_in        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_addr !== 32'h80000000) begin errors++; $display("FAIL reset_addr: got %h expected 80000000", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stream_req%0d: got valid=%b addr=%h expected valid=1 addr=%h", i, imem_req_valid, imem_addr, exp_pc); end
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000013;
      #1;
      checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_wait%0d: got req_valid=%b out_valid=%b expected 0 0", i, imem_req_valid, out_valid); end
      step();
      imem_rsp_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== 32'h00000013) begin errors++; $display("FAIL stream_out%0d: got valid=%b pc=%h inst=%h expected 1 %h 00000013", i, out_valid, out_pc, out_inst, exp_pc); end
      step();
      exp_pc = exp_pc + 32'd4;
    end
    out_ready = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stream_count: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
    step();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80000000 || out_inst !== 32'h00500093 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall%0d: got valid=%b pc=%h inst=%h req=%b expected 1 80000000 00500093 0", i, out_valid, out_pc, out_inst, imem_req_valid); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80000004) begin errors++; $display("FAIL stall_release: got valid=%b addr=%h expected 1 80000004", imem_req_valid, imem_addr); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", fetch_count); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80000103;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_hold: got out=%b req=%b expected 0 0", out_valid, imem_req_valid); end
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    step();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_out: got %b expected 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80000100) begin errors++; $display("FAIL redir_new_req: got valid=%b addr=%h expected 1 80000100", imem_req_valid, imem_addr); end
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A00113;
    step();
    imem_rsp_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80000100 || out_inst !== 32'h00A00113) begin errors++; $display("FAIL redir_out: got valid=%b pc=%h inst=%h expected 1 80000100 00a00113", out_valid, out_pc, out_inst); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_out();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000013;
    step();
    imem_rsp_valid = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80001000;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_out_valid: got %b expected 0", out_valid); end
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL redir_out_count: got %0d expected 0", fetch_count); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80001000) begin errors++; $display("FAIL redir_out_addr: got valid=%b addr=%h expected 1 80001000", imem_req_valid, imem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100073;
    step();
    imem_rsp_valid = 1'b0; out_ready = 1'b1; halt_in = 1'b1;
    #1;
    checks++; if (out_inst !== 32'h00100073) begin errors++; $display("FAIL halt_inst: got %h expected 00100073", out_inst); end
    step();
    out_ready = 1'b0; halt_in = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_state: got halted=%b req=%b out=%b expected 1 0 0", halted, imem_req_valid, out_valid); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL halt_count: got %0d expected 1", fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h80002000; imem_rsp_valid = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
    step();
    step();
    #1;
    checks++; if (halted !== 1'b1 || imem_addr !== 32'h80000000 || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky: got halted=%b addr=%h out=%b req=%b expected 1 80000000 0 0", halted, imem_addr, out_valid, imem_req_valid); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL halt_count_sticky: got %0d expected 1", fetch_count); end
    do_reset();
    #1;
    checks++; if (halted !== 1'b0 || imem_addr !== 32'h80000000 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL halt_reset: got halted=%b addr=%h req=%b expected 0 80000000 1", halted, imem_addr, imem_req_valid); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEBABE;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80000000 || out_valid !== 1'b0) begin errors++; $display("FAIL rstwait_req: got req=%b addr=%h out=%b expected 1 80000000 0", imem_req_valid, imem_addr, out_valid); end
    step();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rstwait_ignored: got out=%b req=%b expected 0 1", out_valid, imem_req_valid); end
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000013;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00000013 || out_pc !== 32'h80000000) begin errors++; $display("FAIL rstwait_refetch: got valid=%b inst=%h pc=%h expected 1 00000013 80000000", out_valid, out_inst, out_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_halt();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
